centroid_update: RTL and testbench
==================================

Name: centroid_update

Overview:
- Downstream of the cluster compare elements: consumes (point, assigned cluster index) pairs produced by the nearest-centre search for one k-means iteration.
- Accumulates per-cluster component sums and counts, then on `finish` computes each cluster mean with a sequential divider.
- Emits the new centres one at a time over a valid/ready handshake and flags convergence against the previous iteration's centres.

Parameters:
- dim, 3, number of point components; packing assumes 3.
- data_range, 255, max component value; dim_size = $clog2(data_range), center_size = dim*dim_size; component d at bits [d*dim_size +: dim_size].
- k, 8, number of clusters (>=2); idx_size = $clog2(k).
- max_points, 1023, max points per iteration; cnt_size = $clog2(max_points+1); per-component sum width = dim_size+cnt_size.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  point/index pair valid.
- in_ready  out  1  block can accept a pair.
- in_point  in  center_size  packed point.
- in_idx  in  idx_size  assigned cluster.
- finish  in  1  single-cycle pulse: last point delivered, start update.
- out_valid  out  1  new centre valid.
- out_ready  in  1  consumer accepts centre.
- out_idx  out  idx_size  cluster of out_center.
- out_center  out  center_size  new packed centre.
- out_empty  out  1  cluster received no points; out_center is the previous centre.
- done  out  1  one-cycle pulse after the last centre is accepted.
- converged  out  1  valid with done: no centre changed this iteration.

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high.
- Reset (also mid-operation): state ACCUM; all sums, counts, total counter and previous-centre bank cleared to 0; out_valid=0, out_idx=0, out_center=0, out_empty=0, done=0, converged=0; in_ready=1 from the first cycle after reset.
- ACCUM:
  - in_ready=1 unless total accepted == max_points.
  - On in_valid&&in_ready: sum[in_idx][d] += in_point[d] for every d; cnt[in_idx] += 1; total += 1.
  - in_idx >= k: pair accepted but discarded (no sum/count change; total still increments).
  - finish in ACCUM: a pair handshaken in the same cycle is included. Next state is DIV with cluster c=0, component d=0.
  - finish in any other state is ignored.
- DIV:
  - in_ready=0.
  - If cnt[c]==0: go to EMIT next cycle with out_center = prev[c] and out_empty=1.
  - Otherwise, restoring division sum[c][d]/cnt[c] producing dim_size quotient bits MSB-first, one bit per cycle.
  - Truncation (floor); no rounding.
  - The quotient always fits dim_size bits because mean <= data_range.
  - dim*dim_size cycles per non-empty cluster (24 at defaults), then EMIT with out_empty=0.
- EMIT:
  - out_valid=1, with out_idx, out_center and out_empty stable until out_valid&&out_ready.
  - On handshake:
    - changed flag |= (out_center != prev[c]);
    - prev[c] <= out_center; sum[c] and cnt[c] cleared.
    - If c==k-1, go to DONE; else c+1 and go to DIV.
  - out_valid deasserts the cycle after the handshake.
- DONE:
  - done=1 for exactly one cycle; converged = !changed (held until the next done).
  - total and changed cleared; return to ACCUM.
- Convergence: the previous-centre bank starts at 0 after reset, so the first iteration converges only if every new centre is 0.
- Concurrency:
  - No input is accepted outside ACCUM.
  - Output backpressure stalls only EMIT; the divider state is held.

Test Plan:
- Reset, then pairs to idx 2: (10,20,30), (11,21,31), (12,23,35); then finish -> clusters 0,1 emit out_empty=1, out_center=0. Cluster 2 emits out_center=0x20150B (mean 11,21,32) 24 DIV cycles after cluster 1's handshake. Then done=1, converged=0.
- Repeat an identical second iteration -> all k centres equal prev, converged=1 on done.
- Truncation: idx 0 points (1,1,1) and (2,2,2) -> mean (1,1,1), out_center=0x010101.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT -> out_valid and out_center stable, no advance; advance only on the handshake.
- Simultaneous in_valid and finish in ACCUM -> that point is included in the sums. Pairs with in_idx out of range (k=6 instance, idx 7) are discarded.
- Feed max_points pairs -> in_ready=0 afterwards. Assert rst during DIV -> next cycle out_valid=0, in_ready=1, prev bank 0.

Source files
------------

// File: rtl/centroid_update.sv
// k-means centre update: accumulates per-cluster sums/counts, divides serially on finish,
// and streams the new centres out with a convergence flag against the previous iteration.
module centroid_update #(
  parameter int dim        = 3,
  parameter int data_range = 255,
  parameter int k          = 8,
  parameter int max_points = 1023,
  localparam int dim_size    = $clog2(data_range),
  localparam int center_size = dim * dim_size,
  localparam int idx_size    = $clog2(k),
  localparam int cnt_size    = $clog2(max_points + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [center_size-1:0] in_point,
  input  logic [idx_size-1:0]    in_idx,
  input  logic                   finish,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [idx_size-1:0]    out_idx,
  output logic [center_size-1:0] out_center,
  output logic                   out_empty,
  output logic                   done,
  output logic                   converged
);

  localparam int SW = dim_size + cnt_size;
  localparam int DW = (dim > 1) ? $clog2(dim) : 1;
  localparam int BW = $clog2(dim_size);

  localparam logic [BW-1:0]       BIT_TOP   = BW'(dim_size - 1);
  localparam logic [DW-1:0]       D_LAST    = DW'(dim - 1);
  localparam logic [idx_size-1:0] C_LAST    = idx_size'(k - 1);
  localparam logic [cnt_size-1:0] TOTAL_MAX = cnt_size'(max_points);
  localparam logic [idx_size:0]   K_L       = (idx_size + 1)'(k);

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [idx_size-1:0]    c_q, c_d;
  logic [DW-1:0]          d_q, d_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [SW-1:0]          rem_q, rem_d, div_q, div_d;
  logic [dim_size-2:0]    qacc_q, qacc_d;
  logic [center_size-1:0] center_q, center_d;
  logic                   empty_q, empty_d;
  logic [cnt_size-1:0]    total_q, total_d;
  logic                   changed_q, changed_d;
  logic                   conv_q, conv_d;

  logic [SW-1:0]          sum_q  [k][dim];
  logic [cnt_size-1:0]    cnt_q  [k];
  logic [center_size-1:0] prev_q [k];

  logic          accept, store, emit_hs, ge, differs;
  logic [SW-1:0] cur_rem, cur_div;

  assign in_ready   = (state_q == S_ACCUM) && (total_q != TOTAL_MAX);
  assign out_valid  = (state_q == S_EMIT);
  assign done       = (state_q == S_DONE);
  assign converged  = conv_q;
  assign out_idx    = c_q;
  assign out_center = center_q;
  assign out_empty  = empty_q;

  assign accept  = in_valid && in_ready;
  assign store   = accept && ({1'b0, in_idx} < K_L);
  assign emit_hs = out_valid && out_ready;
  assign differs = (center_q != prev_q[c_q]);

  // The first bit of each component reloads the dividend and the fully shifted divisor.
  assign cur_rem = (bit_q == BIT_TOP) ? sum_q[c_q][d_q] : rem_q;
  assign cur_div = (bit_q == BIT_TOP) ? (SW'(cnt_q[c_q]) << (dim_size - 1)) : div_q;
  assign ge      = (cur_rem >= cur_div);

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    div_d     = div_q;
    qacc_d    = qacc_q;
    center_d  = center_q;
    empty_d   = empty_q;
    total_d   = total_q;
    changed_d = changed_q;
    conv_d    = conv_q;
    case (state_q)
      S_ACCUM: begin
        if (accept) total_d = total_q + 1'b1;
        if (finish) begin
          state_d = S_DIV;
          c_d     = '0;
          d_d     = '0;
          bit_d   = BIT_TOP;
        end
      end
      S_DIV: begin
        if (cnt_q[c_q] == '0) begin
          state_d  = S_EMIT;
          center_d = prev_q[c_q];
          empty_d  = 1'b1;
        end else begin
          rem_d  = ge ? (cur_rem - cur_div) : cur_rem;
          div_d  = cur_div >> 1;
          qacc_d = {qacc_q[dim_size-3:0], ge};
          if (bit_q == '0) begin
            bit_d = BIT_TOP;
            // Finished components enter at the top and drift down, so component 0 ends at the LSBs.
            center_d = {qacc_q, ge, center_q[center_size-1:dim_size]};
            if (d_q == D_LAST) begin
              state_d = S_EMIT;
              empty_d = 1'b0;
            end else begin
              d_d = d_q + 1'b1;
            end
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (emit_hs) begin
          changed_d = changed_q | differs;
          if (c_q == C_LAST) begin
            state_d = S_DONE;
            conv_d  = !(changed_q | differs);
          end else begin
            state_d = S_DIV;
            c_d     = c_q + 1'b1;
            d_d     = '0;
            bit_d   = BIT_TOP;
          end
        end
      end
      default: begin
        state_d   = S_ACCUM;
        total_d   = '0;
        changed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ACCUM;
      c_q       <= '0;
      d_q       <= '0;
      bit_q     <= BIT_TOP;
      rem_q     <= '0;
      div_q     <= '0;
      qacc_q    <= '0;
      center_q  <= '0;
      empty_q   <= 1'b0;
      total_q   <= '0;
      changed_q <= 1'b0;
      conv_q    <= 1'b0;
      for (int unsigned ci = 0; ci < k; ci++) begin
        cnt_q[ci]  <= '0;
        prev_q[ci] <= '0;
        for (int unsigned dd = 0; dd < dim; dd++) sum_q[ci][dd] <= '0;
      end
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      d_q       <= d_d;
      bit_q     <= bit_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      qacc_q    <= qacc_d;
      center_q  <= center_d;
      empty_q   <= empty_d;
      total_q   <= total_d;
      changed_q <= changed_d;
      conv_q    <= conv_d;
      if (store) begin
        cnt_q[in_idx] <= cnt_q[in_idx] + 1'b1;
        for (int unsigned dd = 0; dd < dim; dd++)
          sum_q[in_idx][dd] <= sum_q[in_idx][dd] + SW'(in_point[dd*dim_size +: dim_size]);
      end
      if (emit_hs) begin
        prev_q[c_q] <= center_q;
        cnt_q[c_q]  <= '0;
        for (int unsigned dd = 0; dd < dim; dd++) sum_q[c_q][dd] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_centroid_update.sv
// Directed bench for centroid_update: a k=8 instance is checked cluster by cluster,
// a k=6 instance shares the stimulus to show out-of-range indices are dropped.
module tb_centroid_update;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, finish, out_ready;
  logic [23:0] in_point;
  logic [2:0]  in_idx;

  logic        in_ready, out_valid, out_empty, done, converged;
  logic [2:0]  out_idx;
  logic [23:0] out_center;

  logic        o6_in_ready, o6_valid, o6_empty, o6_done, o6_conv;
  logic [2:0]  o6_idx;
  logic [23:0] o6_center;

  centroid_update #(.dim(3), .data_range(255), .k(8), .max_points(1023)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_point(in_point), .in_idx(in_idx), .finish(finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_center(out_center), .out_empty(out_empty), .done(done), .converged(converged)
  );

  centroid_update #(.dim(3), .data_range(255), .k(6), .max_points(1023)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o6_in_ready),
    .in_point(in_point), .in_idx(in_idx), .finish(finish),
    .out_valid(o6_valid), .out_ready(out_ready), .out_idx(o6_idx),
    .out_center(o6_center), .out_empty(o6_empty), .done(o6_done), .converged(o6_conv)
  );

  int          n_err = 0;
  int          n_chk = 0;
  logic [23:0] tb_prev [8];
  logic [23:0] exp_c   [8];
  logic        exp_e   [8];
  logic [23:0] d6_c    [8];
  int          d6_dones;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (o6_valid && out_ready) d6_c[o6_idx] = o6_center;
    @(posedge clk);
    #1;
    if (o6_done) d6_dones++;
  endtask

  task automatic send(input logic [2:0] idx, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic fin);
    in_valid = 1'b1;
    in_idx   = idx;
    in_point = {c, b, a};
    finish   = fin;
    check("in_ready_accum", in_ready, 1);
    tick();
    in_valid = 1'b0;
    finish   = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic prep();
    for (int c = 0; c < 8; c++) begin
      exp_c[c] = tb_prev[c];
      exp_e[c] = 1'b1;
    end
  endtask

  // Call right after the finish edge; hold_c < 0 disables the backpressure hold.
  task automatic run_iter(input int hold_c, input logic exp_conv);
    int          lat;
    logic [23:0] held;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == hold_c) out_ready = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
        tick();
        lat++;
      end
      check("valid_seen", out_valid, 1);
      check("div_latency", lat, exp_e[c] ? 1 : 24);
      check("out_idx", out_idx, c);
      check("out_center", out_center, exp_c[c]);
      check("out_empty", out_empty, exp_e[c]);
      if (c == hold_c) begin
        held = out_center;
        repeat (5) begin
          tick();
          check("bp_valid", out_valid, 1);
          check("bp_idx", out_idx, c);
          check("bp_center", out_center, held);
        end
        out_ready = 1'b1;
      end
      tick();
      check("valid_drop", out_valid, 0);
      if (c < 7) check("no_early_done", done, 0);
    end
    check("done", done, 1);
    check("converged", converged, exp_conv);
    tick();
    check("done_pulse", done, 0);
    check("conv_hold", converged, exp_conv);
    check("in_ready_back", in_ready, 1);
    for (int c = 0; c < 8; c++) tb_prev[c] = exp_c[c];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; finish = 1'b0; out_ready = 1'b0;
    in_idx = '0; in_point = '0; d6_dones = 0;
    for (int c = 0; c < 8; c++) begin
      tb_prev[c] = '0;
      d6_c[c]    = '0;
    end
    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_center", out_center, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_done", done, 0);
    check("rst_converged", converged, 0);

    // Iteration 1: mean (11,21,32) into cluster 2
    send(3'd2, 8'd10, 8'd20, 8'd30, 1'b0);
    send(3'd2, 8'd11, 8'd21, 8'd31, 1'b0);
    send(3'd2, 8'd12, 8'd23, 8'd35, 1'b0);
    pulse_finish();
    prep();
    exp_c[2] = 24'h20150B; exp_e[2] = 1'b0;
    run_iter(-1, 1'b0);

    // Iteration 2: identical data converges
    send(3'd2, 8'd10, 8'd20, 8'd30, 1'b0);
    send(3'd2, 8'd11, 8'd21, 8'd31, 1'b0);
    send(3'd2, 8'd12, 8'd23, 8'd35, 1'b0);
    pulse_finish();
    prep();
    exp_c[2] = 24'h20150B; exp_e[2] = 1'b0;
    run_iter(-1, 1'b1);

    // Iteration 3: truncation 3/2 -> 1, with backpressure on cluster 0
    send(3'd0, 8'd1, 8'd1, 8'd1, 1'b0);
    send(3'd0, 8'd2, 8'd2, 8'd2, 1'b0);
    pulse_finish();
    prep();
    exp_c[0] = 24'h010101; exp_e[0] = 1'b0;
    run_iter(0, 1'b0);

    // Iteration 4: point with concurrent finish counts; idx 7 only exists in the k=8 instance
    d6_dones = 0;
    for (int c = 0; c < 8; c++) d6_c[c] = 24'hFFFFFF;
    send(3'd7, 8'd200, 8'd200, 8'd200, 1'b0);
    send(3'd1, 8'd4, 8'd4, 8'd4, 1'b0);
    send(3'd1, 8'd6, 8'd8, 8'd10, 1'b1);
    prep();
    exp_c[1] = 24'h070605;  exp_e[1] = 1'b0;
    exp_c[7] = 24'hC8C8C8;  exp_e[7] = 1'b0;
    run_iter(-1, 1'b0);
    check("k6_done_count", d6_dones, 1);
    check("k6_c0_prev", d6_c[0], 24'h010101);
    check("k6_c1_mean", d6_c[1], 24'h070605);
    check("k6_c5_prev", d6_c[5], 24'h000000);

    // Fill to max_points, then reset in the middle of the divide
    in_valid = 1'b1; in_idx = 3'd0; in_point = {8'd5, 8'd5, 8'd5};
    repeat (1022) tick();
    check("in_ready_1022", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("in_ready_full", in_ready, 0);
    pulse_finish();
    check("in_ready_div", in_ready, 0);
    repeat (3) tick();
    check("div_no_valid", out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_center", out_center, 0);

    // Empty iteration after reset: all centres come from a cleared bank
    for (int c = 0; c < 8; c++) tb_prev[c] = '0;
    pulse_finish();
    prep();
    run_iter(-1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
